// File: rtl/mem_stage_pkg.sv
// Shared definitions for the bexkat1 memory stage: instruction field
// positions, memory instruction type codes, the pipeline NOP, the memory
// access width and bus FSM state enums, and the width decode helper.
package bexkat1Def;

    // Fields of the 64-bit instruction word used by the memory stage
    localparam int IR_TYPE_HI  = 31;
    localparam int IR_TYPE_LO  = 28;
    localparam int IR_WIDTH_HI = 25;
    localparam int IR_WIDTH_LO = 24;

    localparam logic [3:0]  T_LOAD  = 4'h6;
    localparam logic [3:0]  T_STORE = 4'h7;
    localparam logic [63:0] NOP_IR  = 64'h0;

    typedef enum logic [1:0] {
        MW_WORD = 2'd0,
        MW_HALF = 2'd1,
        MW_BYTE = 2'd2
    } mem_width_t;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUS  = 1'b1
    } mem_state_t;

    // Width code 3 is unassigned and behaves as a full word access
    function automatic mem_width_t decode_width(input logic [1:0] op);
        case (op)
            2'd1:    return MW_HALF;
            2'd2:    return MW_BYTE;
            default: return MW_WORD;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane.sv
// Byte-lane steering for big-endian bus accesses: lane select, store data
// replication and zero-extended load extraction.
// Latency: purely combinational. Backpressure: none, no state.
// Ports: width/addr choose the lanes; store_dat -> wdat, load_dat -> rdat.
// Low address bits below the access width are ignored, so a word access
// always uses lanes 1111 and a halfword never straddles the word halves.
module mem_lane
    import bexkat1Def::*;
(
    input  mem_width_t  width,
    input  logic [1:0]  addr,
    input  logic [31:0] store_dat,
    input  logic [31:0] load_dat,
    output logic [3:0]  sel,
    output logic [31:0] wdat,
    output logic [31:0] rdat
);

    always_comb begin
        sel  = 4'b1111;
        wdat = store_dat;
        rdat = load_dat;
        case (width)
            MW_HALF: begin
                // Lower address lives in the upper lanes (big-endian)
                sel  = addr[1] ? 4'b0011 : 4'b1100;
                wdat = {2{store_dat[15:0]}};
                rdat = {16'h0, (addr[1] ? load_dat[15:0] : load_dat[31:16])};
            end
            MW_BYTE: begin
                sel  = 4'b1000 >> addr;
                wdat = {4{store_dat[7:0]}};
                case (addr)
                    2'd0:    rdat = {24'h0, load_dat[31:24]};
                    2'd1:    rdat = {24'h0, load_dat[23:16]};
                    2'd2:    rdat = {24'h0, load_dat[15:8]};
                    default: rdat = {24'h0, load_dat[7:0]};
                endcase
            end
            default: begin
                sel  = 4'b1111;
                wdat = store_dat;
                rdat = load_dat;
            end
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// bexkat1 memory stage: runs one load/store bus cycle per memory instruction,
// passes everything else to wb. Latency: 1 cycle for non-memory ops, 1 idle
// cycle plus bus cycle for memory ops. Backpressure: stall_o holds upstream
// while a bus cycle is pending; wb never backpressures this stage.
// Ports: clk_i/rst_i (sync, active high); ir/pc/ccr/reg_write/result/store
// from execute; registered ir/pc/ccr/reg_write/result to wb; bus master
// cyc/stb/we/adr/sel/dat_o with dat_i/ack_i return.
// Optional: BEXKAT1_MEM_ALIGN_CHECK_EN adds misalignment detection and the
// align_exc_o output; misaligned accesses then skip the bus cycle.
module mem_stage
    import bexkat1Def::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [63:0]   ir_i,
    input  logic [31:0]   pc_i,
    input  logic [2:0]    ccr_i,
    input  logic [1:0]    reg_write_i,
    input  logic [31:0]   result_i,
    input  logic [31:0]   store_i,
    output logic          stall_o,
    output logic [63:0]   ir_o,
    output logic [31:0]   pc_o,
    output logic [2:0]    ccr_o,
    output logic [1:0]    reg_write_o,
    output logic [31:0]   result_o,
    output logic          bus_cyc_o,
    output logic          bus_stb_o,
    output logic          bus_we_o,
    output logic [AW-3:0] bus_adr_o,
    output logic [3:0]    bus_sel_o,
    output logic [31:0]   bus_dat_o,
    input  logic [31:0]   bus_dat_i,
`ifdef BEXKAT1_MEM_ALIGN_CHECK_EN
    output logic          align_exc_o,
`endif
    input  logic          bus_ack_i
);

    if (DW != 32) begin : g_dw_check
        $error("mem_stage: DW must be 32");
    end

    mem_state_t  state;
    logic        is_load;
    logic        is_store;
    logic        is_mem;
    logic        start_bus;
    logic        misaligned;
    mem_width_t  width;
    logic [3:0]  lane_sel;
    logic [31:0] lane_wdat;
    logic [31:0] lane_rdat;

    assign is_load  = (ir_i[IR_TYPE_HI:IR_TYPE_LO] == T_LOAD);
    assign is_store = (ir_i[IR_TYPE_HI:IR_TYPE_LO] == T_STORE);
    assign is_mem   = is_load | is_store;
    assign width    = decode_width(ir_i[IR_WIDTH_HI:IR_WIDTH_LO]);

`ifdef BEXKAT1_MEM_ALIGN_CHECK_EN
    always_comb begin
        misaligned = 1'b0;
        if (is_mem) begin
            case (width)
                MW_WORD: misaligned = |result_i[1:0];
                MW_HALF: misaligned = result_i[0];
                default: misaligned = 1'b0;
            endcase
        end
    end
`else
    assign misaligned = 1'b0;
`endif

    assign start_bus = is_mem & ~misaligned;

    // Upstream inputs stay frozen while this is high, so the held
    // instruction can be decoded straight from the inputs in every state.
    always_comb begin
        stall_o = 1'b0;
        if (!rst_i) begin
            case (state)
                S_IDLE:  stall_o = start_bus;
                S_BUS:   stall_o = ~bus_ack_i;
                default: stall_o = 1'b0;
            endcase
        end
    end

    mem_lane u_lane (
        .width     (width),
        .addr      (result_i[1:0]),
        .store_dat (store_i),
        .load_dat  (bus_dat_i),
        .sel       (lane_sel),
        .wdat      (lane_wdat),
        .rdat      (lane_rdat)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= S_IDLE;
            ir_o        <= NOP_IR;
            pc_o        <= '0;
            ccr_o       <= '0;
            reg_write_o <= '0;
            result_o    <= '0;
            bus_cyc_o   <= 1'b0;
            bus_stb_o   <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_adr_o   <= '0;
            bus_sel_o   <= '0;
            bus_dat_o   <= '0;
`ifdef BEXKAT1_MEM_ALIGN_CHECK_EN
            align_exc_o <= 1'b0;
`endif
        end else begin
`ifdef BEXKAT1_MEM_ALIGN_CHECK_EN
            align_exc_o <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    if (start_bus) begin
                        state       <= S_BUS;
                        bus_cyc_o   <= 1'b1;
                        bus_stb_o   <= 1'b1;
                        bus_we_o    <= is_store;
                        bus_adr_o   <= result_i[AW-1:2];
                        bus_sel_o   <= lane_sel;
                        bus_dat_o   <= lane_wdat;
                        // wb sees a bubble until the bus cycle retires
                        ir_o        <= NOP_IR;
                        reg_write_o <= '0;
                    end else begin
                        ir_o        <= ir_i;
                        pc_o        <= pc_i;
                        ccr_o       <= ccr_i;
                        reg_write_o <= misaligned ? 2'b00 : reg_write_i;
                        result_o    <= result_i;
`ifdef BEXKAT1_MEM_ALIGN_CHECK_EN
                        align_exc_o <= misaligned;
`endif
                    end
                end
                S_BUS: begin
                    if (bus_ack_i) begin
                        state       <= S_IDLE;
                        bus_cyc_o   <= 1'b0;
                        bus_stb_o   <= 1'b0;
                        bus_we_o    <= 1'b0;
                        ir_o        <= ir_i;
                        pc_o        <= pc_i;
                        ccr_o       <= ccr_i;
                        reg_write_o <= reg_write_i;
                        result_o    <= is_load ? lane_rdat : result_i;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    bus_cyc_o <= 1'b0;
                    bus_stb_o <= 1'b0;
                    bus_we_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: table of instructions with expected bus
// and wb results, a scoreboard queue of wb expectations, plus hand-written
// sequences for reset, mid-cycle reset and ack-while-idle.
module tb_mem_stage;
    import bexkat1Def::*;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [63:0] ir_i;
    logic [31:0] pc_i;
    logic [2:0]  ccr_i;
    logic [1:0]  reg_write_i;
    logic [31:0] result_i;
    logic [31:0] store_i;
    logic        stall_o;
    logic [63:0] ir_o;
    logic [31:0] pc_o;
    logic [2:0]  ccr_o;
    logic [1:0]  reg_write_o;
    logic [31:0] result_o;
    logic        bus_cyc_o;
    logic        bus_stb_o;
    logic        bus_we_o;
    logic [29:0] bus_adr_o;
    logic [3:0]  bus_sel_o;
    logic [31:0] bus_dat_o;
    logic [31:0] bus_dat_i;
    logic        bus_ack_i;
`ifdef BEXKAT1_MEM_ALIGN_CHECK_EN
    logic        align_exc_o;
`endif

    always #5 clk_i = ~clk_i;

    mem_stage dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .ir_i        (ir_i),
        .pc_i        (pc_i),
        .ccr_i       (ccr_i),
        .reg_write_i (reg_write_i),
        .result_i    (result_i),
        .store_i     (store_i),
        .stall_o     (stall_o),
        .ir_o        (ir_o),
        .pc_o        (pc_o),
        .ccr_o       (ccr_o),
        .reg_write_o (reg_write_o),
        .result_o    (result_o),
        .bus_cyc_o   (bus_cyc_o),
        .bus_stb_o   (bus_stb_o),
        .bus_we_o    (bus_we_o),
        .bus_adr_o   (bus_adr_o),
        .bus_sel_o   (bus_sel_o),
        .bus_dat_o   (bus_dat_o),
        .bus_dat_i   (bus_dat_i),
`ifdef BEXKAT1_MEM_ALIGN_CHECK_EN
        .align_exc_o (align_exc_o),
`endif
        .bus_ack_i   (bus_ack_i)
    );

    typedef struct {
        logic [3:0]  typ;
        logic [1:0]  wop;
        logic [31:0] pc;
        logic [2:0]  ccr;
        logic [1:0]  rw;
        logic [31:0] result;
        logic [31:0] store;
        logic [31:0] rdata;
        int          delay;      // stb cycles with ack low before ack
        bit          mem;        // a bus cycle is expected
        bit          we;
        logic [29:0] adr;
        logic [3:0]  sel;
        bit          chk_dat;
        logic [31:0] dat;
        logic [31:0] exp_result;
        logic [1:0]  exp_rw;
        int          exp_stall;
        bit          exp_exc;
    } vec_t;

    typedef struct {
        logic [63:0] ir;
        logic [31:0] pc;
        logic [2:0]  ccr;
        logic [1:0]  rw;
        logic [31:0] result;
        bit          exc;
    } exp_t;

    vec_t vecs[$];
    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] mk_ir(input logic [3:0] typ, input logic [1:0] wop, input int idx);
        logic [7:0] tag;
        tag = idx[7:0];
        return {24'hABCDEF, tag, typ, 2'b00, wop, 24'h5A5A5A};
    endfunction

    task automatic drive(input logic [63:0] ir, input vec_t v);
        ir_i        = ir;
        pc_i        = v.pc;
        ccr_i       = v.ccr;
        reg_write_i = v.rw;
        result_i    = v.result;
        store_i     = v.store;
        bus_dat_i   = v.rdata;
    endtask

    // Called at a negedge; returns at the negedge after wb outputs update.
    task automatic run_op(input vec_t v, input int idx);
        logic [63:0] ir;
        exp_t        e;
        int          stalls;
        int          stbc;
        bit          done;
        bit          seen;
        string       tg;
        ir = mk_ir(v.typ, v.wop, idx);
        tg = $sformatf("v%0d", idx);
        e.ir = ir; e.pc = v.pc; e.ccr = v.ccr; e.rw = v.exp_rw;
        e.result = v.exp_result; e.exc = v.exp_exc;
        sb_q.push_back(e);
        drive(ir, v);
        bus_ack_i = 1'b0;
        stalls = 0; stbc = 0; done = 1'b0; seen = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            if (bus_stb_o) begin
                if (!seen) begin
                    seen = 1'b1;
                    check({tg, " adr"}, bus_adr_o, v.adr);
                    check({tg, " sel"}, bus_sel_o, v.sel);
                    check({tg, " we"}, bus_we_o, v.we);
                    check({tg, " cyc"}, bus_cyc_o, 1'b1);
                    check({tg, " bubble rw"}, reg_write_o, 2'b00);
                    check({tg, " bubble ir"}, ir_o, NOP_IR);
                    if (v.chk_dat) check({tg, " dat_o"}, bus_dat_o, v.dat);
                end
                bus_ack_i = (stbc == v.delay);
                stbc++;
            end else begin
                bus_ack_i = 1'b0;
            end
            #1;
            if (stall_o) stalls++;
            else done = 1'b1;
            @(posedge clk_i);
            @(negedge clk_i);
        end
        bus_ack_i = 1'b0;
        if (!done) check({tg, " completion timeout"}, 1'b0, 1'b1);
        check({tg, " stall cycles"}, stalls, v.exp_stall);
        check({tg, " bus cycle seen"}, seen, v.mem);
        e = sb_q.pop_front();
        check({tg, " ir_o"}, ir_o, e.ir);
        check({tg, " pc_o"}, pc_o, e.pc);
        check({tg, " ccr_o"}, ccr_o, e.ccr);
        check({tg, " reg_write_o"}, reg_write_o, e.rw);
        check({tg, " result_o"}, result_o, e.result);
        check({tg, " cyc after"}, bus_cyc_o, 1'b0);
`ifdef BEXKAT1_MEM_ALIGN_CHECK_EN
        check({tg, " align_exc_o"}, align_exc_o, e.exc);
`endif
    endtask

    initial begin
        vec_t v;
        int   guard;
        // typ wop pc ccr rw result store rdata delay mem we adr sel chk dat exp_res exp_rw stall exc
        vecs.push_back('{4'h2, 2'd0, 32'h1000, 3'b101, 2'b11, 32'h1234, 32'h0, 32'h0, 0,
                         1'b0, 1'b0, 30'h0, 4'h0, 1'b0, 32'h0, 32'h1234, 2'b11, 0, 1'b0});
        vecs.push_back('{T_LOAD, 2'd0, 32'h1004, 3'b010, 2'b01, 32'h100, 32'h0, 32'hDEADBEEF, 4,
                         1'b1, 1'b0, 30'h40, 4'hF, 1'b0, 32'h0, 32'hDEADBEEF, 2'b01, 5, 1'b0});
        vecs.push_back('{T_STORE, 2'd2, 32'h1008, 3'b001, 2'b00, 32'h103, 32'h000000A5, 32'hFFFFFFFF, 0,
                         1'b1, 1'b1, 30'h40, 4'h1, 1'b1, 32'hA5A5A5A5, 32'h103, 2'b00, 1, 1'b0});
        vecs.push_back('{T_LOAD, 2'd1, 32'h100C, 3'b100, 2'b01, 32'h102, 32'h0, 32'h11223344, 1,
                         1'b1, 1'b0, 30'h40, 4'h3, 1'b0, 32'h0, 32'h00003344, 2'b01, 2, 1'b0});
        vecs.push_back('{T_LOAD, 2'd1, 32'h1010, 3'b011, 2'b01, 32'h100, 32'h0, 32'h11223344, 2,
                         1'b1, 1'b0, 30'h40, 4'hC, 1'b0, 32'h0, 32'h00001122, 2'b01, 3, 1'b0});
        vecs.push_back('{T_LOAD, 2'd2, 32'h1014, 3'b000, 2'b01, 32'h101, 32'h0, 32'h11223344, 0,
                         1'b1, 1'b0, 30'h40, 4'h4, 1'b0, 32'h0, 32'h00000022, 2'b01, 1, 1'b0});
        vecs.push_back('{T_STORE, 2'd1, 32'h1018, 3'b110, 2'b10, 32'h102, 32'h1234BEEF, 32'h0, 1,
                         1'b1, 1'b1, 30'h40, 4'h3, 1'b1, 32'hBEEFBEEF, 32'h102, 2'b10, 2, 1'b0});
        vecs.push_back('{T_STORE, 2'd0, 32'h101C, 3'b111, 2'b00, 32'h200, 32'h87654321, 32'h0, 0,
                         1'b1, 1'b1, 30'h80, 4'hF, 1'b1, 32'h87654321, 32'h200, 2'b00, 1, 1'b0});
        vecs.push_back('{T_LOAD, 2'd3, 32'h1020, 3'b001, 2'b01, 32'h104, 32'h0, 32'hCAFEF00D, 1,
                         1'b1, 1'b0, 30'h41, 4'hF, 1'b0, 32'h0, 32'hCAFEF00D, 2'b01, 2, 1'b0});
        vecs.push_back('{4'h3, 2'd1, 32'h1024, 3'b010, 2'b01, 32'hFFFFFFFF, 32'h0, 32'h0, 0,
                         1'b0, 1'b0, 30'h0, 4'h0, 1'b0, 32'h0, 32'hFFFFFFFF, 2'b01, 0, 1'b0});
        vecs.push_back('{T_LOAD, 2'd2, 32'h1028, 3'b100, 2'b11, 32'h103, 32'h0, 32'h11223344, 3,
                         1'b1, 1'b0, 30'h40, 4'h1, 1'b0, 32'h0, 32'h00000044, 2'b11, 4, 1'b0});
`ifdef BEXKAT1_MEM_ALIGN_CHECK_EN
        vecs.push_back('{T_LOAD, 2'd0, 32'h102C, 3'b001, 2'b01, 32'h102, 32'h0, 32'h55555555, 0,
                         1'b0, 1'b0, 30'h0, 4'h0, 1'b0, 32'h0, 32'h102, 2'b00, 0, 1'b1});
`else
        vecs.push_back('{T_LOAD, 2'd0, 32'h102C, 3'b001, 2'b01, 32'h102, 32'h0, 32'h55555555, 1,
                         1'b1, 1'b0, 30'h40, 4'hF, 1'b0, 32'h0, 32'h55555555, 2'b01, 2, 1'b0});
`endif
        vecs.push_back('{4'h2, 2'd0, 32'h1030, 3'b000, 2'b00, 32'h0BADF00D, 32'h0, 32'h0, 0,
                         1'b0, 1'b0, 30'h0, 4'h0, 1'b0, 32'h0, 32'h0BADF00D, 2'b00, 0, 1'b0});

        // Reset with a load presented: stall must stay low, outputs at reset values
        rst_i = 1'b1;
        bus_ack_i = 1'b0;
        drive(mk_ir(T_LOAD, 2'd0, 200), vecs[1]);
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        #1;
        check("reset stall_o", stall_o, 1'b0);
        check("reset ir_o", ir_o, NOP_IR);
        check("reset reg_write_o", reg_write_o, 2'b00);
        check("reset result_o", result_o, 32'h0);
        check("reset pc_o", pc_o, 32'h0);
        check("reset cyc", bus_cyc_o, 1'b0);
        check("reset stb", bus_stb_o, 1'b0);
        rst_i = 1'b0;
        drive(mk_ir(4'h2, 2'd0, 201), vecs[0]);
        @(negedge clk_i);

        for (int i = 0; i < vecs.size(); i++) run_op(vecs[i], i);

        // ack while idle is ignored
        v = vecs[0];
        v.result = 32'h00C0FFEE;
        drive(mk_ir(4'h2, 2'd0, 210), v);
        bus_ack_i = 1'b1;
        #1;
        check("idle-ack stall_o", stall_o, 1'b0);
        @(posedge clk_i);
        @(negedge clk_i);
        check("idle-ack cyc", bus_cyc_o, 1'b0);
        check("idle-ack result_o", result_o, 32'h00C0FFEE);
        bus_ack_i = 1'b0;

        // Reset during the wait phase of a bus cycle
        drive(mk_ir(T_LOAD, 2'd0, 220), vecs[1]);
        guard = 0;
        while (!bus_stb_o && guard < 10) begin
            @(posedge clk_i);
            @(negedge clk_i);
            guard++;
        end
        check("midrst stb reached", bus_stb_o, 1'b1);
        @(posedge clk_i);
        @(negedge clk_i);
        #1;
        check("midrst still stalled", stall_o, 1'b1);
        rst_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        #1;
        check("midrst cyc", bus_cyc_o, 1'b0);
        check("midrst stb", bus_stb_o, 1'b0);
        check("midrst ir_o", ir_o, NOP_IR);
        check("midrst result_o", result_o, 32'h0);
        check("midrst stall_o", stall_o, 1'b0);
        rst_i = 1'b0;
        run_op(vecs[1], 230);
        run_op(vecs[3], 231);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
